// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, validates the start bit and samples each
// bit at mid-cell using rising edges of a 16x oversampling clock.
module uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 uart_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_status,
  output logic                 frame_err
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 status_q, status_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_meta_q, rx_s_q;
  logic                 uart_clk_d_q;
  logic                 tick;

  assign tick = uart_clk & ~uart_clk_d_q;

  // Synchronizer flops idle high so reset never looks like a start bit.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      uart_clk_d_q <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      uart_clk_d_q <= uart_clk;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      status_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      status_q <= status_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    status_d = 1'b0;
    ferr_d   = ferr_q;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            cnt_d   = 4'd0;
          end
        end
        S_START: begin
          if (cnt_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d = S_DATA;
              cnt_d   = 4'd0;
              idx_d   = '0;
              ferr_d  = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == 4'd15) begin
            // LSB arrives first, so shifting in at the MSB lands it at bit 0.
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            cnt_d   = 4'd0;
            idx_d   = idx_q + IDX_ONE;
            if (idx_q == IDX_LAST) state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == 4'd15) begin
            if (rx_s_q) begin
              data_d   = shift_q;
              status_d = 1'b1;
              state_d  = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_BREAK: begin
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_status = status_q;
  assign frame_err = ferr_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver for the peripheral bus, consuming the 16× oversampling square wave from the UART clock generator (9600 baud from 50 MHz sysclk). It synchronizes the serial line, detects and validates the start bit, samples each bit at mid-cell, and presents the received byte with a one-cycle valid pulse to the peripheral register block. It also flags stop-bit errors.

## Interface
- DATA_BITS, 8, number of data bits per frame (LSB first); no parity, one stop bit
- sysclk  input  1  system clock (50 MHz), sole clock of the block
- reset  input  1  asynchronous, active-low reset
- uart_clk  input  1  16× baud square wave from the clock generator, synchronous to sysclk; only its rising edge is used
- rx  input  1  serial line, asynchronous, idle high
- rx_data  output  DATA_BITS  last correctly framed byte
- rx_status  output  1  one-sysclk pulse when rx_data is updated
- frame_err  output  1  stop bit sampled low on the most recent frame

## Operation
- One clock, sysclk. Reset is asynchronous and active-low.
- rx passes through a 2-flop synchronizer (rx_s); both flops reset to 1.
- tick = uart_clk & ~uart_clk_d. uart_clk_d is registered and resets to 0. All state advances happen only on sysclk edges where tick=1.
- Registers: 4-bit sample counter cnt, bit index, DATA_BITS shift register, and state.
- IDLE: tick & rx_s==0 -> START, cnt<=0.
- START: on each tick, if cnt==7, sample rx_s:
  - rx_s==0 -> DATA, cnt<=0, bit index<=0, frame_err<=0.
  - rx_s==1 (glitch/false start) -> IDLE, no output change.
  - Otherwise cnt<=cnt+1.
- DATA: on each tick, if cnt==15, shift rx_s into the MSB (so the first bit ends at bit 0), cnt<=0, bit index+1. After the DATA_BITS-th sample -> STOP. Otherwise cnt<=cnt+1.
- STOP: on each tick, if cnt==15, sample rx_s:
  - rx_s==1 -> rx_data<=shift register, rx_status<=1, -> IDLE.
  - rx_s==0 -> frame_err<=1, rx_data unchanged, no rx_status, -> BREAK.
  - Otherwise cnt<=cnt+1.
- BREAK: stay until tick & rx_s==1 -> IDLE. This prevents a held-low line from re-triggering START.
- Reset values: rx_data=0, rx_status=0, frame_err=0, state=IDLE, cnt=0, shift register=0.
- Reset mid-frame aborts immediately: the partial byte is discarded and all outputs return to reset values.

## Timing
- Sampling offsets, counting the START-entry tick as tick 0:
  - start bit sampled at tick 8
  - data bit k sampled at tick 8+16(k+1)
  - stop bit sampled at tick 8+16(DATA_BITS+1) = 152 for 8 bits
- rx_data and rx_status update on the same sysclk edge that samples the stop bit.
- rx_status is high for exactly one sysclk cycle.
- rx_data holds its value until the next good frame. frame_err holds until the next validated start bit.
- Input latency: 2 sysclk (synchronizer) plus up to one tick period before the falling edge is detected.
- A falling edge of rx that arrives while the block is in START, DATA or STOP is ignored. Back-to-back frames with a single stop bit are received without loss, because IDLE is re-entered at the stop-bit midpoint.
- uart_clk held high or low produces no tick, and the FSM freezes in its current state.

## Test plan
- Reset: reset=0 with rx toggling and uart_clk running -> rx_data=0x00, rx_status=0, frame_err=0. After release with rx=1, the block stays IDLE.
- Single byte: uart_clk period 16 sysclk (sim-scaled), send 0xA5 8N1 at 16 ticks/bit -> rx_data=0xA5, one rx_status pulse at tick 152, frame_err=0.
- Back-to-back: send 0x00, 0xFF, 0x3C consecutively with no idle gap -> three rx_status pulses, with rx_data 0x00, 0xFF, 0x3C in order.
- False start: rx low for 4 ticks, then high -> return to IDLE, no rx_status, rx_data unchanged. A subsequent 0x5A is then received correctly.
- Framing error / break: send 0x81 with stop bit 0, hold rx low 40 ticks, then high, then send 0x42:
  - first frame -> frame_err=1, no pulse, rx_data keeps its previous value
  - 0x42 -> frame_err clears at its start bit, then rx_data=0x42 with one pulse
- Reset mid-frame: assert reset after data bit 3 of 0xC3 -> outputs return to 0. A following 0x99 is received correctly.
